key_event_decoder: RTL

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

---
 rtl/key_event_pkg.sv | 15 +
 rtl/key_event_decoder.sv | 108 ++++++++++
 2 files changed

// File: rtl/key_event_pkg.sv
// Shared types and default timing constants for the key event decoder.
// Default thresholds assume a 50 MHz clock.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } key_state_t;

  localparam int unsigned LONG_CYCLES_DEF   = 50_000_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 10_000_000;
  localparam int unsigned CNT_W_DEF         = 26;

endpackage

// File: rtl/key_event_decoder.sv
// Turns debounced press/release pulses into short/long/repeat events.
// Auto-repeat is built only when KEY_EVENT_REPEAT_EN is defined.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_negedge,
  input  logic key_posedge,
  output logic short_press,
  output logic long_press,
  output logic repeat_tick,
  output logic key_held
);

  localparam int unsigned HOLD_MAX =
    (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  // The counter must be able to reach the largest threshold.
  if ((64'(HOLD_MAX) >> CNT_W) != 64'd0) begin : g_cnt_w_check
    $error("CNT_W too narrow for LONG_CYCLES/REPEAT_CYCLES");
  end

  key_state_t       state;
  logic [CNT_W-1:0] cnt;

  // Both edges in one cycle is a protocol violation and is dropped.
  logic press;
  logic release_k;

  assign press     = key_negedge & ~key_posedge;
  assign release_k = key_posedge & ~key_negedge;

  // Press-tracking FSM with hold counter; all event outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      repeat_tick <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      short_press <= 1'b0;
      long_press  <= 1'b0;
      repeat_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (press) begin
            state    <= PRESSED;
            cnt      <= '0;
            key_held <= 1'b1;
          end
        end
        PRESSED: begin
          if (release_k) begin
            state       <= IDLE;
            cnt         <= '0;
            key_held    <= 1'b0;
            short_press <= 1'b1;
          end else if (cnt == LONG_LAST) begin
            state      <= LONG_HELD;
            cnt        <= '0;
            long_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LONG_HELD: begin
          if (release_k) begin
            state    <= IDLE;
            cnt      <= '0;
            key_held <= 1'b0;
          end else begin
`ifdef KEY_EVENT_REPEAT_EN
            if (cnt == REP_LAST) begin
              cnt         <= '0;
              repeat_tick <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
`else
            cnt <= '0;
`endif
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          key_held <= 1'b0;
        end
      endcase
    end
  end

`ifndef KEY_EVENT_REPEAT_EN
  logic unused_rep;
  assign unused_rep = ^REP_LAST;
`endif

endmodule
